// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions, also reused by the decode and hazard logic.
//   fetch_state_e       : fetch FSM states (issue a request / wait for its response)
//   DEFAULT_BUBBLE_INST : word presented when no valid instruction (matches the F/D flush value)
//   PC_INC              : sequential fetch increment
//   align_pc()          : clears the two low bits of a byte address
package fetch_unit_pkg;

  typedef enum logic {
    StIssue,
    StWait
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC              = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus, one request outstanding at a time.
//   req    : fetch request (fetch side drives)
//   addr   : fetch address
//   gnt    : request accepted this cycle (memory drives)
//   rvalid : response valid, at least one cycle after gnt
//   rdata  : instruction word
// Modports: master = fetch unit, slave = instruction memory.
interface fetch_unit_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit_if_out_buf.sv
// One-entry output buffer holding the fetched word and its pc for the F/D register.
//   clk, rst           : clock, synchronous active-low reset
//   load               : capture load_inst/load_pc and mark valid
//   load_inst, load_pc : word and address to capture
//   consume            : downstream took the held word this cycle
//   kill               : drop the held word (redirect); wins over load and consume
//   out_valid, out_inst, out_pc : buffer contents
module if_out_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_inst,
  input  logic [31:0] load_pc,
  input  logic        consume,
  input  logic        kill,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q, pc_q;

  always_comb begin
    valid_d = valid_q;
    if (kill) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        inst_q <= load_inst;
        pc_q   <= load_pc;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the F/D pipeline register. Owns the fetch pc, runs a
// single-outstanding request/grant/response handshake to instruction memory, buffers the
// returned word, honours hazard stall and branch/jump redirect, and discards wrong-path
// responses.
//   clk, rst            : clock, synchronous active-low reset
//   stall               : hazard stall; presented instruction is not consumed while 1
//   redirect            : taken branch/jump pulse, redirect_pc is the target
//   imem                : instruction-memory bus (master side)
//   inst, pc            : presented instruction and its address (bubble / 0 when empty)
//   fetch_busy          : no valid instruction presented
//   misalign            : misaligned redirect seen (only with MISALIGN_CHECK_EN)
// Optional feature macro: MISALIGN_CHECK_EN. Without it the redirect target is word-aligned
// by clearing its low bits and misalign is tied low.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = DEFAULT_BUBBLE_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  inst,
  output logic [31:0]  pc,
  output logic         fetch_busy,
  output logic         misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         drop_q, drop_d;
  logic         misalign_q;
  logic [31:0]  target_pc;
  logic         req;
  logic         load;
  logic         out_valid;
  logic [31:0]  out_inst, out_pc;

`ifdef MISALIGN_CHECK_EN
  logic misalign_d;

  assign target_pc  = redirect_pc;
  // Every redirect re-evaluates alignment, so an aligned one clears the flag.
  assign misalign_d = redirect ? (redirect_pc[1:0] != 2'b00) : misalign_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  logic unused_low_bits;

  assign target_pc       = align_pc(redirect_pc);
  assign misalign_q      = 1'b0;
  assign unused_low_bits = ^redirect_pc[1:0];
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    req        = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIssue: begin
        // Issue whenever the buffer is free or about to be consumed; a late rvalid here
        // (e.g. after reset abandoned a request) is ignored.
        req = (!out_valid || !stall) && !misalign_q;
        if (req && imem.gnt) begin
          state_d = StWait;
          // Request already went out to the old path.
          if (redirect) drop_d = 1'b1;
        end
      end
      StWait: begin
        if (imem.rvalid) begin
          state_d = StIssue;
          drop_d  = 1'b0;
          if (!drop_q && !redirect) begin
            load       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_INC;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
    endcase

    if (redirect) fetch_pc_d = target_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIssue;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  // Buffer is guaranteed empty when a response lands (single outstanding request).
  if_out_buf u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_inst (imem.rdata),
    .load_pc   (fetch_pc_q),
    .consume   (out_valid && !stall),
    .kill      (redirect),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
  );

  assign imem.req   = req && rst;
  assign imem.addr  = fetch_pc_q;
  assign inst       = out_valid ? out_inst : BUBBLE_INST;
  assign pc         = out_valid ? out_pc : 32'h0;
  assign fetch_busy = !out_valid;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized stall,
// redirect, reset and memory timing, checked every cycle against a transaction-level model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_busy;
  logic        misalign;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .inst        (inst),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Memory environment state and knobs.
  bit          mem_busy = 1'b0;
  int unsigned mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int unsigned gnt_mode = 1;  // 0: never, 1: always, 2: random
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;
  bit          spur_en  = 1'b0;

  // Reference model: presented instruction, next fetch address, one outstanding request.
  bit          m_ov     = 1'b0;
  logic [31:0] m_out_pc = '0;
  logic [31:0] m_out_inst = '0;
  logic [31:0] m_next   = '0;
  bit          m_wait   = 1'b0;
  bit          m_wrong  = 1'b0;
  bit          m_mis    = 1'b0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'hDEAD_BEEF;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    if ($urandom_range(0, 7) == 0) begin
      t = 32'hFFFF_FFF8;
    end else begin
      t = $urandom_range(0, 1023) * 4;
    end
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle; entered and left at posedge+1 with inputs already driven.
  task automatic step();
    logic        exp_req;
    logic        fill;
    logic [31:0] tgt;
    if (mem_busy) imem_bus.gnt = 1'b0;
    else if (gnt_mode == 0) imem_bus.gnt = 1'b0;
    else if (gnt_mode == 1) imem_bus.gnt = 1'b1;
    else imem_bus.gnt = ($urandom_range(0, 9) < 6);
    if (mem_busy && mem_cnt == 0) begin
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = word_at(mem_addr);
    end else if (!mem_busy && spur_en && $urandom_range(0, 29) == 0) begin
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = $urandom;
    end else begin
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = $urandom;
    end

    @(negedge clk);
    exp_req = rst && !m_wait && (!m_ov || !stall) && !m_mis;
    check("imem_req", 32'(imem_bus.req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_bus.addr, m_next);
    check("inst", inst, m_ov ? m_out_inst : 32'h0);
    check("pc", pc, m_ov ? m_out_pc : 32'h0);
    check("fetch_busy", 32'(fetch_busy), 32'(!m_ov));
    check("misalign", 32'(misalign), 32'(m_mis));

    if (!rst) begin
      m_ov = 1'b0; m_next = 32'h0; m_wait = 1'b0; m_wrong = 1'b0; m_mis = 1'b0;
    end else begin
`ifdef MISALIGN_CHECK_EN
      tgt = redirect_pc;
`else
      tgt = {redirect_pc[31:2], 2'b00};
`endif
      fill = m_wait && imem_bus.rvalid && !m_wrong && !redirect;
      if (redirect) m_ov = 1'b0;
      else if (fill) m_ov = 1'b1;
      else if (m_ov && !stall) m_ov = 1'b0;
      if (fill) begin
        m_out_pc   = m_next;
        m_out_inst = imem_bus.rdata;
        m_next     = m_next + 32'd4;
      end
      if (!m_wait) begin
        if (exp_req && imem_bus.gnt) begin
          m_wait  = 1'b1;
          m_wrong = redirect;
        end
      end else if (imem_bus.rvalid) begin
        m_wait  = 1'b0;
        m_wrong = 1'b0;
      end else if (redirect) begin
        m_wrong = 1'b1;
      end
      if (redirect) begin
        m_next = tgt;
`ifdef MISALIGN_CHECK_EN
        m_mis = (redirect_pc[1:0] != 2'b00);
`endif
      end
    end

    if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
    if (imem_bus.req && imem_bus.gnt) begin
      mem_busy = 1'b1;
      mem_addr = imem_bus.addr;
      mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
    end else if (mem_busy && mem_cnt != 0) begin
      mem_cnt--;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = '0;
    @(posedge clk);
    #1;

    // Reset held: no requests.
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("first_req", 32'(imem_bus.req), 32'h1);
    check("first_addr", imem_bus.addr, 32'h0);

    // gnt always, rvalid one cycle later.
    repeat (2) step();
    check("first_inst", inst, 32'h0050_0093);
    check("first_pc", pc, 32'h0);
    check("second_addr", imem_bus.addr, 32'h4);

    // Stall while the second word is held.
    repeat (2) step();
    stall = 1'b1;
    repeat (3) step();
    check("stall_inst", inst, 32'h00A0_0113);
    check("stall_pc", pc, 32'h4);
    check("stall_req", 32'(imem_bus.req), 32'h0);
    gnt_mode = 0;
    stall    = 1'b0;
    #1;
    check("unstall_req", 32'(imem_bus.req), 32'h1);
    check("unstall_addr", imem_bus.addr, 32'h8);

    // No grant for four cycles.
    repeat (4) step();
    check("nognt_req", 32'(imem_bus.req), 32'h1);
    check("nognt_addr", imem_bus.addr, 32'h8);
    check("nognt_inst", inst, 32'h0);
    check("nognt_busy", 32'(fetch_busy), 32'h1);

    // Redirect while waiting; the 0xDEADBEEF response must be dropped.
    gnt_mode = 1;
    lat_min  = 3;
    lat_max  = 3;
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    repeat (2) step();
    check("drop_busy", 32'(fetch_busy), 32'h1);
    check("drop_inst", inst, 32'h0);
    check("drop_req", 32'(imem_bus.req), 32'h1);
    check("drop_addr", imem_bus.addr, 32'h100);

    // Redirect coinciding with rvalid.
    repeat (3) step();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    check("coinc_busy", 32'(fetch_busy), 32'h1);
    check("coinc_req", 32'(imem_bus.req), 32'h1);
    check("coinc_addr", imem_bus.addr, 32'h200);

`ifdef MISALIGN_CHECK_EN
    redirect    = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    repeat (3) step();
    check("mis_flag", 32'(misalign), 32'h1);
    check("mis_req", 32'(imem_bus.req), 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h104;
    step();
    redirect = 1'b0;
    check("mis_clear", 32'(misalign), 32'h0);
    check("mis_req2", 32'(imem_bus.req), 32'h1);
    check("mis_addr", imem_bus.addr, 32'h104);
`endif

    // Let the sequential stream run briefly, then randomize everything.
    repeat (6) step();
    gnt_mode = 2;
    lat_min  = 1;
    lat_max  = 4;
    spur_en  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) != 0);
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = rand_target();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
